// File: rtl/bark_pkg.sv
// Shared types for the decode/execute boundary: datapath widths, ALU opcode
// encoding and the resolved-instruction record held in the ID/EX register.
package bark_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    // 32-bit encoding so the opcode can be passed to the ALU unchanged.
    typedef enum logic [31:0] {
        AluAdd = 32'd0,
        AluSub = 32'd1,
        AluAnd = 32'd2,
        AluOr  = 32'd3,
        AluXor = 32'd4
    } alu_op_t;

    typedef struct packed {
        alu_op_t           alu_op;
        logic [XLEN-1:0]   operand1;
        logic [XLEN-1:0]   operand2;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
    } ex_instr_t;

    // A write-back candidate targets a source when it is enabled and the indices agree.
    function automatic logic reg_match(input logic              we,
                                       input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs);
        return we && (rd == rs);
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand: x0 zeroing, EX > MEM > WB > register-file
// priority mux, and the read-after-write hazard check for that operand.
// Build option: FORWARDING_EN selects the bypass network; without it the
// operand always comes from the register file and matches raise a hazard.
module operand_bypass
    import bark_pkg::*;
(
    input  logic [REG_AW-1:0] rs_i,
    input  logic [XLEN-1:0]   rs_data_i,
    input  logic              used_i,
    input  logic              ex_we_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [XLEN-1:0]   ex_data_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic              wb_we_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic [XLEN-1:0]   operand_o,
    output logic              hazard_o
);

    logic rs_zero;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    assign rs_zero = (rs_i == '0);
    assign ex_hit  = reg_match(ex_we_i, ex_rd_i, rs_i);
    assign mem_hit = reg_match(mem_we_i, mem_rd_i, rs_i);
    assign wb_hit  = reg_match(wb_we_i, wb_rd_i, rs_i);

`ifdef FORWARDING_EN
    // With bypassing every operand is always available, so usage does not matter.
    logic unused_used;
    assign unused_used = used_i;

    // Youngest producer wins; x0 is hard-wired and never bypassed.
    always_comb begin
        operand_o = rs_data_i;
        hazard_o  = 1'b0;
        if (rs_zero) begin
            operand_o = '0;
        end else if (ex_hit) begin
            operand_o = ex_data_i;
        end else if (mem_hit) begin
            operand_o = mem_data_i;
        end else if (wb_hit) begin
            operand_o = wb_data_i;
        end
    end
`else
    // Producer data is never consumed when the bypass network is absent.
    logic unused_data;
    assign unused_data = ^{ex_data_i, mem_data_i, wb_data_i};

    // Register file only; any in-flight writer of a used, nonzero source stalls
    // (including WB, as the register file does not write through).
    always_comb begin
        operand_o = rs_zero ? '0 : rs_data_i;
        hazard_o  = used_i && !rs_zero && (ex_hit || mem_hit || wb_hit);
    end
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register in front of the ALU. Accepts decoded instructions
// on a valid/ready handshake, resolves both operands at transfer time and
// holds alu_control/operands stable for the combinational ALU. Counts hazard
// stall cycles in a saturating counter.
// Build option: FORWARDING_EN enables the EX/MEM/WB bypass network.
module id_ex_stage
    import bark_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_alu_op,
    input  logic [REG_AW-1:0]      in_rs1,
    input  logic [REG_AW-1:0]      in_rs2,
    input  logic [XLEN-1:0]        in_rs1_data,
    input  logic [XLEN-1:0]        in_rs2_data,
    input  logic [XLEN-1:0]        in_imm,
    input  logic                   in_use_imm,
    input  logic [REG_AW-1:0]      in_rd,
    input  logic                   in_rd_we,

    input  logic                   flush,

    input  logic [XLEN-1:0]        ex_result,
    input  logic                   mem_we,
    input  logic [REG_AW-1:0]      mem_rd,
    input  logic [XLEN-1:0]        mem_data,
    input  logic                   wb_we,
    input  logic [REG_AW-1:0]      wb_rd,
    input  logic [XLEN-1:0]        wb_data,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_alu_control,
    output logic [XLEN-1:0]        out_operand1,
    output logic [XLEN-1:0]        out_operand2,
    output logic [REG_AW-1:0]      out_rd,
    output logic                   out_rd_we,

    output logic [STALL_CNT_W-1:0] stall_count
);

    ex_instr_t              out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic                   ex_we;
    logic [XLEN-1:0]        rs1_operand;
    logic [XLEN-1:0]        rs2_operand;
    logic                   rs1_hazard;
    logic                   rs2_hazard;
    logic                   hazard;
    logic                   transfer;
    ex_instr_t              resolved;

    // The instruction in our own output register is the EX-stage producer.
    assign ex_we = out_valid_q && out_q.rd_we;

    operand_bypass u_bypass_rs1 (
        .rs_i       (in_rs1),
        .rs_data_i  (in_rs1_data),
        .used_i     (1'b1),
        .ex_we_i    (ex_we),
        .ex_rd_i    (out_q.rd),
        .ex_data_i  (ex_result),
        .mem_we_i   (mem_we),
        .mem_rd_i   (mem_rd),
        .mem_data_i (mem_data),
        .wb_we_i    (wb_we),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .operand_o  (rs1_operand),
        .hazard_o   (rs1_hazard)
    );

    operand_bypass u_bypass_rs2 (
        .rs_i       (in_rs2),
        .rs_data_i  (in_rs2_data),
        .used_i     (!in_use_imm),
        .ex_we_i    (ex_we),
        .ex_rd_i    (out_q.rd),
        .ex_data_i  (ex_result),
        .mem_we_i   (mem_we),
        .mem_rd_i   (mem_rd),
        .mem_data_i (mem_data),
        .wb_we_i    (wb_we),
        .wb_rd_i    (wb_rd),
        .wb_data_i  (wb_data),
        .operand_o  (rs2_operand),
        .hazard_o   (rs2_hazard)
    );

    // Handshake: no skid buffer, so ready depends on the downstream consume.
    always_comb begin
        hazard   = rs1_hazard || rs2_hazard;
        in_ready = !hazard && (!out_valid_q || out_ready);
        transfer = in_valid && in_ready;
    end

    // Assemble the resolved instruction presented to the output register.
    always_comb begin
        resolved          = '0;
        resolved.alu_op   = alu_op_t'(in_alu_op);
        resolved.operand1 = rs1_operand;
        resolved.operand2 = in_use_imm ? in_imm : rs2_operand;
        resolved.rd       = in_rd;
        resolved.rd_we    = in_rd_we;
    end

    // Output register next state: flush beats transfer beats drain beats hold.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (transfer) begin
            out_d       = resolved;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Stall counter saturates at all-ones rather than wrapping.
    always_comb begin
        stall_d = stall_q;
        if (in_valid && hazard && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
        end
    end

    // Drive outputs straight from the registers so the ALU sees stable values.
    always_comb begin
        out_valid       = out_valid_q;
        out_alu_control = out_q.alu_op;
        out_operand1    = out_q.operand1;
        out_operand2    = out_q.operand2;
        out_rd          = out_q.rd;
        out_rd_we       = out_q.rd_we;
        stall_count     = stall_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage. Build-dependent sequences
// are selected with FORWARDING_EN to match the RTL build.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_use_imm, in_rd_we;
    logic        flush;
    logic [31:0] ex_result, mem_data, wb_data;
    logic        mem_we, wb_we;
    logic [4:0]  mem_rd, wb_rd;
    logic        out_valid, out_ready;
    logic [31:0] out_alu_control, out_operand1, out_operand2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [15:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage #(.STALL_CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_alu_op       (in_alu_op),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .in_imm          (in_imm),
        .in_use_imm      (in_use_imm),
        .in_rd           (in_rd),
        .in_rd_we        (in_rd_we),
        .flush           (flush),
        .ex_result       (ex_result),
        .mem_we          (mem_we),
        .mem_rd          (mem_rd),
        .mem_data        (mem_data),
        .wb_we           (wb_we),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_alu_control (out_alu_control),
        .out_operand1    (out_operand1),
        .out_operand2    (out_operand2),
        .out_rd          (out_rd),
        .out_rd_we       (out_rd_we),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid, flush, out_ready;
        logic [31:0] op;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1_data, rs2_data, imm;
        logic        use_imm, rd_we;
        logic [31:0] ex_result, mem_data, wb_data;
        logic        mem_we, wb_we;
        logic [4:0]  mem_rd, wb_rd;
        logic        e_in_ready, e_valid, e_chk;
        logic [31:0] e_op, e_op1, e_op2;
        logic [4:0]  e_rd;
        logic        e_rd_we;
        logic [15:0] e_stall;
    } vec_t;

    vec_t tbl[$];
    vec_t v;

    function automatic vec_t instr(input logic [31:0] op, input logic [4:0] rs1,
                                   input logic [31:0] d1, input logic [4:0] rs2,
                                   input logic [31:0] d2, input logic use_imm,
                                   input logic [31:0] imm, input logic [4:0] rd,
                                   input logic rd_we);
        vec_t r;
        r = '{default: '0};
        r.in_valid = 1'b1;
        r.out_ready = 1'b1;
        r.op = op; r.rs1 = rs1; r.rs1_data = d1; r.rs2 = rs2; r.rs2_data = d2;
        r.use_imm = use_imm; r.imm = imm; r.rd = rd; r.rd_we = rd_we;
        return r;
    endfunction

    function automatic vec_t expect_out(input vec_t r, input logic rdy, input logic vld,
                                        input logic chk, input logic [31:0] op,
                                        input logic [31:0] op1, input logic [31:0] op2,
                                        input logic [4:0] rd, input logic rd_we,
                                        input logic [15:0] stall);
        vec_t o;
        o = r;
        o.e_in_ready = rdy; o.e_valid = vld; o.e_chk = chk; o.e_op = op;
        o.e_op1 = op1; o.e_op2 = op2; o.e_rd = rd; o.e_rd_we = rd_we; o.e_stall = stall;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        in_valid = r.in_valid; flush = r.flush; out_ready = r.out_ready;
        in_alu_op = r.op; in_rs1 = r.rs1; in_rs2 = r.rs2; in_rd = r.rd;
        in_rs1_data = r.rs1_data; in_rs2_data = r.rs2_data; in_imm = r.imm;
        in_use_imm = r.use_imm; in_rd_we = r.rd_we;
        ex_result = r.ex_result; mem_we = r.mem_we; mem_rd = r.mem_rd;
        mem_data = r.mem_data; wb_we = r.wb_we; wb_rd = r.wb_rd; wb_data = r.wb_data;
    endtask

    // Drive after the falling edge, check ready before the rising edge and the
    // registered outputs just after it.
    task automatic apply(input vec_t r, input string name);
        @(negedge clk);
        drive(r);
        #1;
        check({name, " in_ready"}, {31'b0, in_ready}, {31'b0, r.e_in_ready});
        @(posedge clk);
        #1;
        check({name, " out_valid"}, {31'b0, out_valid}, {31'b0, r.e_valid});
        check({name, " stall_count"}, {16'b0, stall_count}, {16'b0, r.e_stall});
        if (r.e_chk) begin
            check({name, " alu_control"}, out_alu_control, r.e_op);
            check({name, " operand1"}, out_operand1, r.e_op1);
            check({name, " operand2"}, out_operand2, r.e_op2);
            check({name, " out_rd"}, {27'b0, out_rd}, {27'b0, r.e_rd});
            check({name, " out_rd_we"}, {31'b0, out_rd_we}, {31'b0, r.e_rd_we});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles with a valid instruction offered.
        rst_n = 1'b0;
        drive(instr(32'd0, 5'd1, 32'h5, 5'd2, 32'h6, 1'b0, 32'h0, 5'd3, 1'b1));
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset alu_control", out_alu_control, 32'd0);
        check("reset operand1", out_operand1, 32'd0);
        check("reset operand2", out_operand2, 32'd0);
        check("reset out_rd", {27'b0, out_rd}, 32'd0);
        check("reset out_rd_we", {31'b0, out_rd_we}, 32'd0);
        check("reset stall_count", {16'b0, stall_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        check("post-reset in_ready", {31'b0, in_ready}, 32'd1);

        // Build-independent vectors: no producer ever matches a used source.
        tbl.push_back(expect_out(instr(0, 1, 32'h5, 0, 0, 1, 32'h7, 10, 1),
                                 1, 1, 1, 0, 32'h5, 32'h7, 10, 1, 0));
        tbl.push_back(expect_out(instr(1, 2, 32'h100, 4, 32'h30, 0, 0, 11, 1),
                                 1, 1, 1, 1, 32'h100, 32'h30, 11, 1, 0));
        tbl.push_back(expect_out(instr(2, 0, 32'hDEAD, 5, 32'hF0F0, 0, 0, 12, 1),
                                 1, 1, 1, 2, 32'h0, 32'hF0F0, 12, 1, 0));
        tbl.push_back(expect_out(instr(3, 6, 32'h1, 12, 32'h55, 1, 32'hFFFF_FFFF, 13, 0),
                                 1, 1, 1, 3, 32'h1, 32'hFFFF_FFFF, 13, 0, 0));
        tbl.push_back(expect_out(instr(4, 7, 32'hAAAA, 0, 32'h1234, 0, 0, 14, 1),
                                 1, 1, 1, 4, 32'hAAAA, 32'h0, 14, 1, 0));
        // Three cycles of backpressure: outputs hold, new input refused.
        for (int i = 0; i < 3; i++) begin
            v = expect_out(instr(0, 8, 32'h9, 0, 0, 1, 32'h1, 15, 1),
                           0, 1, 1, 4, 32'hAAAA, 32'h0, 14, 1, 0);
            v.out_ready = 1'b0;
            tbl.push_back(v);
        end
        // Flush while stalled, then flush with ready high: input not taken.
        v = expect_out(instr(0, 8, 32'h9, 0, 0, 1, 32'h1, 15, 1), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.out_ready = 1'b0; v.flush = 1'b1;
        tbl.push_back(v);
        v = expect_out(instr(0, 8, 32'h9, 0, 0, 1, 32'h1, 15, 1), 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v.flush = 1'b1;
        tbl.push_back(v);
        v = expect_out(instr(0, 8, 32'h9, 0, 0, 1, 32'h1, 15, 1), 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v.in_valid = 1'b0;
        tbl.push_back(v);
        tbl.push_back(expect_out(instr(0, 9, 32'h3, 0, 0, 1, 32'h4, 15, 1),
                                 1, 1, 1, 0, 32'h3, 32'h4, 15, 1, 0));
        // Consume with nothing new: bubble.
        v = expect_out(instr(0, 9, 32'h3, 0, 0, 1, 32'h4, 15, 1), 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v.in_valid = 1'b0;
        tbl.push_back(v);
        tbl.push_back(expect_out(instr(1, 1, 32'h2, 2, 32'h1, 0, 0, 1, 1),
                                 1, 1, 1, 1, 32'h2, 32'h1, 1, 1, 0));
        // Back-to-back: consume and load in the same cycle.
        tbl.push_back(expect_out(instr(2, 3, 32'h33, 0, 0, 1, 32'hF, 2, 1),
                                 1, 1, 1, 2, 32'h33, 32'hF, 2, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

`ifdef FORWARDING_EN
        // Out register now holds rd=2; load rd=3 as the EX producer.
        apply(expect_out(instr(0, 0, 32'h99, 0, 0, 1, 32'h0, 3, 1),
                         1, 1, 1, 0, 32'h0, 32'h0, 3, 1, 0), "fwd_setup");
        // EX beats MEM and WB.
        v = expect_out(instr(0, 3, 32'h99, 0, 0, 1, 32'h1, 4, 1),
                       1, 1, 1, 0, 32'h10, 32'h1, 4, 1, 0);
        v.ex_result = 32'h10; v.mem_we = 1; v.mem_rd = 3; v.mem_data = 32'h20;
        v.wb_we = 1; v.wb_rd = 3; v.wb_data = 32'h30;
        apply(v, "fwd_ex_prio");
        // MEM beats WB on rs1; EX bypass on rs2.
        v = expect_out(instr(1, 6, 32'h99, 4, 32'h98, 0, 0, 7, 1),
                       1, 1, 1, 1, 32'h60, 32'h40, 7, 1, 0);
        v.ex_result = 32'h40; v.mem_we = 1; v.mem_rd = 6; v.mem_data = 32'h60;
        v.wb_we = 1; v.wb_rd = 6; v.wb_data = 32'h61;
        apply(v, "fwd_mem_prio");
        // Only WB matches.
        v = expect_out(instr(0, 5, 32'h99, 0, 0, 1, 32'h2, 8, 1),
                       1, 1, 1, 0, 32'h50, 32'h2, 8, 1, 0);
        v.ex_result = 32'h1; v.wb_we = 1; v.wb_rd = 5; v.wb_data = 32'h50;
        apply(v, "fwd_wb_only");
        // x0 is never bypassed.
        v = expect_out(instr(3, 0, 32'h99, 0, 0, 1, 32'h3, 9, 1),
                       1, 1, 1, 3, 32'h0, 32'h3, 9, 1, 0);
        v.mem_we = 1; v.mem_rd = 0; v.mem_data = 32'hFF;
        apply(v, "fwd_x0");
        // After a bubble the stale out register must not bypass.
        v = expect_out(instr(0, 9, 32'h12, 0, 0, 1, 32'h0, 10, 1), 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v.in_valid = 1'b0;
        apply(v, "fwd_bubble");
        v = expect_out(instr(0, 9, 32'h12, 0, 0, 1, 32'h0, 10, 1),
                       1, 1, 1, 0, 32'h12, 32'h0, 10, 1, 0);
        v.ex_result = 32'hEE;
        apply(v, "fwd_no_stale_ex");
`else
        // Out register holds rd=2 (valid). rs1 matches MEM then WB: two stall cycles.
        v = expect_out(instr(0, 20, 32'h77, 0, 0, 1, 32'h1, 21, 1), 0, 0, 0, 0, 0, 0, 0, 0, 1);
        v.mem_we = 1; v.mem_rd = 20; v.mem_data = 32'hAA;
        apply(v, "nofwd_mem_stall");
        v = expect_out(instr(0, 20, 32'h77, 0, 0, 1, 32'h1, 21, 1), 0, 0, 0, 0, 0, 0, 0, 0, 2);
        v.wb_we = 1; v.wb_rd = 20; v.wb_data = 32'hBB;
        apply(v, "nofwd_wb_stall");
        apply(expect_out(instr(0, 20, 32'h77, 0, 0, 1, 32'h1, 21, 1),
                         1, 1, 1, 0, 32'h77, 32'h1, 21, 1, 2), "nofwd_release");
        // rs2 matches the out register: stall, bubble downstream, then go.
        apply(expect_out(instr(1, 1, 32'h5, 21, 32'h6, 0, 0, 22, 1),
                         0, 0, 0, 0, 0, 0, 0, 0, 3), "nofwd_ex_stall");
        apply(expect_out(instr(1, 1, 32'h5, 21, 32'h6, 0, 0, 22, 1),
                         1, 1, 1, 1, 32'h5, 32'h6, 22, 1, 3), "nofwd_ex_release");
        // Unused rs2 and x0 sources never stall.
        v = expect_out(instr(2, 0, 32'h99, 5, 32'h9, 1, 32'hC, 23, 1),
                       1, 1, 1, 2, 32'h0, 32'hC, 23, 1, 3);
        v.mem_we = 1; v.mem_rd = 5; v.wb_we = 1; v.wb_rd = 0;
        apply(v, "nofwd_unused_src");
`endif

        @(negedge clk);
        in_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that sits directly upstream of the ALU. It accepts decoded instructions over a valid/ready handshake and resolves both source operands. Resolution uses register-file data, an immediate, or bypassed results. It then registers alu_control, operand1 and operand2 so the combinational ALU computes from stable values. It also tracks hazard stall cycles for performance debug.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register index width
- STALL_CNT_W, 16, width of the stall counter
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid / in_ready  in / out  1  upstream handshake; transfer on in_valid && in_ready
- in_alu_op  in  32  ALU opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4
- in_rs1, in_rs2  in  REG_AW  source register indices
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_use_imm  in  1  operand2 takes in_imm instead of rs2
- in_rd  in  REG_AW  destination register index
- in_rd_we  in  1  destination register write enable
- flush  in  1  kill the held instruction and the input
- ex_result  in  XLEN  ALU result for the instruction currently in this stage's output register
- mem_we, mem_rd, mem_data  in  1 / REG_AW / XLEN  EX/MEM-stage write-back candidate
- wb_we, wb_rd, wb_data  in  1 / REG_AW / XLEN  WB-stage write-back candidate
- out_valid / out_ready  out / in  1  downstream handshake
- out_alu_control  out  32  opcode to the ALU
- out_operand1, out_operand2  out  XLEN  operands to the ALU
- out_rd  out  REG_AW  destination index carried to the next stage
- out_rd_we  out  1  destination write enable carried to the next stage
- stall_count  out  STALL_CNT_W  saturating count of hazard stall cycles

## Operation
**Handshake**
- in_ready = !hazard && (!out_valid || out_ready). The path is combinational; there is no skid buffer.
- On transfer, the output register loads the resolved instruction and out_valid=1.
- If out_valid && out_ready and there is no transfer, out_valid drops to 0 (a bubble).
- While out_valid && !out_ready, all out_* hold their values.

**Operand resolution (evaluated at transfer only)**
- operand1 comes from rs1.
- operand2 comes from in_imm if in_use_imm, else from rs2.
- A register source with index 0 always resolves to 0 and is never bypassed.
- Bypass priority is EX > MEM > WB > register file:
  - EX match: out_valid && out_rd_we && out_rd==rs, using ex_result.
  - MEM match: mem_we && mem_rd==rs.
  - WB match: wb_we && wb_rd==rs.
- The operand is only used when it is needed. rs2 is ignored when in_use_imm.

**Flush**
- out_valid=0 on the next edge. The input is not accepted that cycle.
- Flush has priority over transfer and over hold.

**Hazards**
- With bypassing compiled in, hazard=0.

**stall_count**
- Increments when in_valid && hazard.
- Saturates at all-ones and never wraps.

## Timing
- Latency is one cycle from transfer to out_valid.
- Throughput is one instruction per cycle when out_ready=1.
- Reset values:
  - out_valid=0.
  - out_alu_control, out_operand1, out_operand2, out_rd, out_rd_we = 0.
  - stall_count=0.
  - in_ready=1 on the first cycle after rst_n rises.
- Reset asserted mid-stall discards the held instruction. No transfer occurs while rst_n=0.
- Simultaneous out consume and in transfer: the new instruction loads and out_valid stays 1. ex_result bypass applies to the departing instruction.

## Configuration
- FORWARDING_EN defined:
  - Full EX/MEM/WB bypass network.
  - hazard is always 0.
  - stall_count stays 0.
- FORWARDING_EN undefined:
  - No bypass; operands come from in_*_data or in_imm only.
  - hazard=1 when any used, nonzero source matches one of:
    - the out register rd (out_valid && out_rd_we),
    - mem_rd (mem_we),
    - wb_rd (wb_we).
  - The register file is not write-through, so the WB match also stalls.
  - ex_result and the *_data bypass inputs are unused.

## Structure
- Shared package bark_pkg contains:
  - XLEN and REG_AW.
  - alu_op_t, a 32-bit encoded opcode enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - The resolved-instruction struct (alu_op, operand1, operand2, rd, rd_we).
- Sub-module operand_bypass, instantiated once per source operand. It contains the index-0 zeroing, the priority mux and the hazard match for that operand.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, all outputs 0, stall_count=0; in_ready=1 after release.
- Basic with immediate: ADD, rs1=1 with data 5, in_use_imm=1, imm=7 -> next cycle out_valid=1, op1=5, op2=7, out_alu_control=0.
- Bypass priority (FORWARDING_EN):
  - Setup: out reg holds rd=3, ex_result=0x10; mem_rd=3 with mem_data=0x20.
  - Stimulus: next instruction with rs1=3.
  - Required: op1=0x10.
  - Follow-up: with only WB matching, op1=wb_data.
- x0: rs1=0, mem_we=1, mem_rd=0, mem_data=0xFF -> op1=0.
- Backpressure and flush:
  - out_ready=0 for 3 cycles -> outputs stable, in_ready=0, stall_count unchanged.
  - Then flush=1 -> out_valid=0 next cycle and the input is not accepted.
- No-forwarding build: rs1 matches mem_rd, then wb_rd, over 2 cycles -> in_ready=0 for 2 cycles, stall_count=2, then transfer with op1=in_rs1_data.
